// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed multi-digit seven-segment driver.
// Captures packed nibbles into a pending buffer, promotes them to the
// display buffer only at frame boundaries, and scans one digit at a time
// onto a shared segment bus with a one-hot digit enable.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int HEX_EN     = 0,
    parameter int LZ_BLANK   = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    output logic [6:0]                seven_seg_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     digit_sel,
    output logic                      frame_done
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PW-1:0]             presc;
    logic [IW-1:0]             idx;
    logic [4*NUM_DIGITS-1:0]   pending;
    logic [NUM_DIGITS-1:0]     pending_dp;
    logic                      pending_valid;
    logic [4*NUM_DIGITS-1:0]   display;
    logic [NUM_DIGITS-1:0]     display_dp;

    logic                      tick;
    logic                      wrap;
    logic [PW-1:0]             presc_next;
    logic [IW-1:0]             idx_next;
    logic [4*NUM_DIGITS-1:0]   display_next;
    logic [NUM_DIGITS-1:0]     display_dp_next;
    logic [NUM_DIGITS-1:0]     sel_next;
    logic [NUM_DIGITS-1:0]     blank_vec;
    logic                      zero_above;
    logic [3:0]                nibble;
    logic                      dp_sel;
    logic                      blank_sel;
    logic [6:0]                seg_next;

    // Nibble to segment pattern {a,b,c,d,e,f,g}; codes above 9 depend on HEX_EN.
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] g;
        g = 7'b1001111;
        case (code)
            4'h0: g = 7'b1111110;
            4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;
            4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;
            4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;
            4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1111011;
            4'hA: g = (HEX_EN != 0) ? 7'b1110111 : 7'b1001111;
            4'hB: g = (HEX_EN != 0) ? 7'b0011111 : 7'b1001111;
            4'hC: g = (HEX_EN != 0) ? 7'b1001110 : 7'b1001111;
            4'hD: g = (HEX_EN != 0) ? 7'b0111101 : 7'b1001111;
            4'hE: g = 7'b1001111;
            4'hF: g = (HEX_EN != 0) ? 7'b1000111 : 7'b1001111;
            default: g = 7'b1001111;
        endcase
        return g;
    endfunction

    // Next-state of scan counters and display buffer, plus the glyph for the next digit.
    always_comb begin
        tick            = enable && (presc == PW'(SCAN_DIV - 1));
        wrap            = tick && (idx == IW'(NUM_DIGITS - 1));
        presc_next      = presc;
        idx_next        = idx;
        display_next    = display;
        display_dp_next = display_dp;
        sel_next        = '0;
        blank_vec       = '0;
        zero_above      = 1'b1;
        nibble          = 4'h0;
        dp_sel          = 1'b0;
        blank_sel       = 1'b0;

        if (enable) begin
            presc_next = tick ? '0 : presc + 1'b1;
        end
        if (tick) begin
            idx_next = wrap ? '0 : idx + 1'b1;
        end

        // A load on the wrap cycle bypasses pending so it shows at this same boundary.
        if (wrap) begin
            if (load) begin
                display_next    = bcd_in;
                display_dp_next = dp_in;
            end else if (pending_valid) begin
                display_next    = pending;
                display_dp_next = pending_dp;
            end
        end

        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above   = zero_above && (display_next[4*i +: 4] == 4'h0);
            blank_vec[i] = (LZ_BLANK != 0) && (i > 0) && zero_above;
        end

        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_next[i] = (idx_next == IW'(i));
            if (idx_next == IW'(i)) begin
                nibble    = display_next[4*i +: 4];
                dp_sel    = display_dp_next[i];
                blank_sel = blank_vec[i];
            end
        end

        seg_next = blank_sel ? 7'b0000000 : decode(nibble);
    end

    // Scan counters, pending/display buffers; load always lands in pending except on the wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc         <= '0;
            idx           <= '0;
            pending       <= '0;
            pending_dp    <= '0;
            pending_valid <= 1'b0;
            display       <= '0;
            display_dp    <= '0;
        end else begin
            presc      <= presc_next;
            idx        <= idx_next;
            display    <= display_next;
            display_dp <= display_dp_next;
            if (load && !wrap) begin
                pending       <= bcd_in;
                pending_dp    <= dp_in;
                pending_valid <= 1'b1;
            end else if (wrap) begin
                pending_valid <= 1'b0;
            end
        end
    end

    // Registered outputs already reflect the index and display being entered on this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_sel     <= '0;
            seven_seg_out <= '0;
            dp_out        <= 1'b0;
            frame_done    <= 1'b0;
        end else if (enable) begin
            digit_sel     <= sel_next;
            seven_seg_out <= seg_next;
            dp_out        <= dp_sel;
            frame_done    <= wrap;
        end else begin
            digit_sel     <= '0;
            seven_seg_out <= '0;
            dp_out        <= 1'b0;
            frame_done    <= 1'b0;
        end
    end

endmodule
